// File: rtl/apu_dmc.sv
// Delta-modulation sample channel: fetches sample bytes over a req/ack port into a
// small FIFO and plays them out as a saturating delta-coded level for the mixer.
module apu_dmc #(
   parameter int OUT_WIDTH = 7,
   parameter int BUF_DEPTH = 1,
   parameter int LEN_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_tick,
   input  logic [7:0]           reg_ctrl,
   input  logic [7:0]           reg_direct,
   input  logic [7:0]           reg_addr,
   input  logic [7:0]           reg_length,
   input  logic                 ctrl_update,
   input  logic                 direct_update,
   input  logic                 addr_update,
   input  logic                 length_update,
   input  logic                 en,
   input  logic                 en_update,
   output logic                 dma_req,
   output logic [15:0]          dma_addr,
   input  logic                 dma_ack,
   input  logic [7:0]           dma_data,
   output logic                 active,
   output logic                 irq,
   output logic [OUT_WIDTH-1:0] sample
);

   localparam logic [OUT_WIDTH-1:0] STEP     = OUT_WIDTH'(2 << (OUT_WIDTH - 7));
   localparam logic [OUT_WIDTH-1:0] HI_LIM   = {OUT_WIDTH{1'b1}} - STEP;
   localparam logic [2:0]           DEPTH    = 3'(BUF_DEPTH);
   localparam logic [1:0]           LAST_PTR = 2'(BUF_DEPTH - 1);

   function automatic logic [8:0] period_m1(input logic [3:0] idx);
      case (idx)
         4'd0:    period_m1 = 9'd427;
         4'd1:    period_m1 = 9'd379;
         4'd2:    period_m1 = 9'd339;
         4'd3:    period_m1 = 9'd319;
         4'd4:    period_m1 = 9'd285;
         4'd5:    period_m1 = 9'd253;
         4'd6:    period_m1 = 9'd225;
         4'd7:    period_m1 = 9'd213;
         4'd8:    period_m1 = 9'd189;
         4'd9:    period_m1 = 9'd159;
         4'd10:   period_m1 = 9'd141;
         4'd11:   period_m1 = 9'd127;
         4'd12:   period_m1 = 9'd105;
         4'd13:   period_m1 = 9'd83;
         4'd14:   period_m1 = 9'd71;
         default: period_m1 = 9'd53;
      endcase
   endfunction

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      ptr_inc = (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   logic [8:0]           timer;
   logic                 out_clk;
   logic [OUT_WIDTH-1:0] level;
   logic [OUT_WIDTH-1:0] direct_lvl;
   logic [7:0]           shift;
   logic [3:0]           bits_left;
   logic                 silence;
   logic [7:0]           fifo_mem [0:3];
   logic [1:0]           rd_ptr;
   logic [1:0]           wr_ptr;
   logic [2:0]           fifo_cnt;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;
   logic                 ack_ok;
   logic [15:0]          cur_addr;
   logic [15:0]          addr_nxt;
   logic [15:0]          start_addr;
   logic [LEN_WIDTH-1:0] bytes_rem;
   logic [LEN_WIDTH-1:0] rem_nxt;
   logic [LEN_WIDTH-1:0] start_len;
   logic                 irq_nxt;
   logic                 unused_ok;

   // The register file lives outside; these strobes and bits carry no extra meaning here.
   assign unused_ok = ^{reg_ctrl[5:4], reg_direct[7], addr_update, length_update};

   assign out_clk    = cpu_tick && (timer == 9'd0);
   assign ack_ok     = dma_req && dma_ack;
   assign push       = ack_ok;
   assign pop        = out_clk && (bits_left == 4'd1) && (fifo_cnt != 3'd0);
   assign fifo_full  = (fifo_cnt == DEPTH);
   assign start_addr = {2'b11, reg_addr, 6'b000000};
   assign start_len  = LEN_WIDTH'({reg_length, 4'b0000}) + LEN_WIDTH'(1);
   assign direct_lvl = OUT_WIDTH'(reg_direct[6:0]) << (OUT_WIDTH - 7);
   assign sample     = level;

   // Memory reader next state; an en_update is applied after any same-cycle ack.
   always_comb begin
      addr_nxt = cur_addr;
      rem_nxt  = bytes_rem;
      irq_nxt  = irq;
      if (ack_ok) begin
         addr_nxt = (cur_addr == 16'hFFFF) ? 16'h8000 : cur_addr + 16'd1;
         if (bytes_rem != '0) begin
            rem_nxt = bytes_rem - LEN_WIDTH'(1);
            if (rem_nxt == '0) begin
               if (reg_ctrl[6]) begin
                  addr_nxt = start_addr;
                  rem_nxt  = start_len;
               end else if (reg_ctrl[7]) begin
                  irq_nxt = 1'b1;
               end
            end
         end
      end
      if (ctrl_update && !reg_ctrl[7]) irq_nxt = 1'b0;
      if (en_update) begin
         irq_nxt = 1'b0;
         if (!en) begin
            rem_nxt = '0;
         end else if (rem_nxt == '0) begin
            addr_nxt = start_addr;
            rem_nxt  = start_len;
         end
      end
   end

   // Handshake: dma_req/dma_addr are held until the one-cycle dma_ack (data valid with it);
   // req drops on the edge that takes the ack and only one request is ever outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= 16'hC000;
         bytes_rem <= '0;
         irq       <= 1'b0;
         active    <= 1'b0;
         dma_req   <= 1'b0;
         dma_addr  <= 16'h0000;
      end else begin
         cur_addr  <= addr_nxt;
         bytes_rem <= rem_nxt;
         irq       <= irq_nxt;
         active    <= (rem_nxt != '0);
         if (dma_req) begin
            if (dma_ack) dma_req <= 1'b0;
         end else if (!fifo_full && (rem_nxt != '0)) begin
            dma_req  <= 1'b1;
            dma_addr <= addr_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= dma_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= 2'd0;
         wr_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
      end
   end

   // Output unit; a direct load overrides any delta applied on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer     <= 9'd0;
         level     <= '0;
         shift     <= 8'h00;
         bits_left <= 4'd8;
         silence   <= 1'b1;
      end else begin
         if (cpu_tick) timer <= (timer == 9'd0) ? period_m1(reg_ctrl[3:0]) : timer - 9'd1;
         if (out_clk) begin
            if (!silence) begin
               if (shift[0] && (level <= HI_LIM))      level <= level + STEP;
               else if (!shift[0] && (level >= STEP)) level <= level - STEP;
            end
            shift <= shift >> 1;
            if (bits_left == 4'd1) begin
               bits_left <= 4'd8;
               if (fifo_cnt != 3'd0) begin
                  shift   <= fifo_mem[rd_ptr];
                  silence <= 1'b0;
               end else begin
                  silence <= 1'b1;
               end
            end else begin
               bits_left <= bits_left - 4'd1;
            end
         end
         if (direct_update) level <= direct_lvl;
      end
   end

endmodule

// File: tb/tb_apu_dmc.sv
// Directed + randomized bench for apu_dmc (7-bit level, 4-deep FIFO) against a
// behavioural model of the delta level and the fetch address sequence.
module tb_apu_dmc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_tick = 1'b1;
   logic [7:0]  reg_ctrl = 8'h0F;
   logic [7:0]  reg_direct = 8'h00;
   logic [7:0]  reg_addr = 8'h00;
   logic [7:0]  reg_length = 8'h00;
   logic        ctrl_update = 1'b0;
   logic        direct_update = 1'b0;
   logic        addr_update = 1'b0;
   logic        length_update = 1'b0;
   logic        en = 1'b0;
   logic        en_update = 1'b0;
   logic        dma_req;
   logic [15:0] dma_addr;
   logic        dma_ack = 1'b0;
   logic [7:0]  dma_data = 8'h00;
   logic        active;
   logic        irq;
   logic [6:0]  sample;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];

   apu_dmc #(.OUT_WIDTH(7), .BUF_DEPTH(4), .LEN_WIDTH(12)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_tick(cpu_tick),
      .reg_ctrl(reg_ctrl), .reg_direct(reg_direct), .reg_addr(reg_addr), .reg_length(reg_length),
      .ctrl_update(ctrl_update), .direct_update(direct_update),
      .addr_update(addr_update), .length_update(length_update),
      .en(en), .en_update(en_update),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_data(dma_data),
      .active(active), .irq(irq), .sample(sample)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model
   function automatic int exp_level(input int start, input logic [7:0] bits);
      int l = start;
      for (int i = 0; i < 8; i++) begin
         if (bits[i]) begin
            if (l + 2 <= 127) l = l + 2;
         end else if (l >= 2) begin
            l = l - 2;
         end
      end
      return l;
   endfunction

   function automatic logic [15:0] start_of(input logic [7:0] a);
      return 16'hC000 + 16'(a) * 16'd64;
   endfunction

   function automatic logic [15:0] next_addr(input logic [15:0] a);
      return (a == 16'hFFFF) ? 16'h8000 : a + 16'd1;
   endfunction

   // driver tasks
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_direct(input logic [7:0] v);
      reg_direct = v;
      direct_update = 1'b1;
      @(negedge clk);
      direct_update = 1'b0;
   endtask

   task automatic pulse_en(input logic e);
      en = e;
      en_update = 1'b1;
      @(negedge clk);
      en_update = 1'b0;
   endtask

   task automatic restart(input logic [7:0] a, input logic [7:0] l);
      reg_addr = a;
      reg_length = l;
      pulse_en(1'b1);
   endtask

   task automatic wait_req(input int bound, output bit got);
      got = 1'b0;
      for (int n = 0; n < bound; n++) begin
         if (dma_req === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic serve(input logic [7:0] data, input int delay, input int bound,
                        output logic [15:0] addr_seen, output bit got);
      wait_req(bound, got);
      addr_seen = 16'h0000;
      if (got) begin
         addr_seen = dma_addr;
         repeat (delay) @(negedge clk);
         dma_data = data;
         dma_ack = 1'b1;
         @(negedge clk);
         dma_ack = 1'b0;
      end
   endtask

   task automatic wait_change(input int bound, output int n, output bit ok);
      logic [6:0] prev;
      prev = sample;
      ok = 1'b0;
      n = 0;
      while (n < bound) begin
         @(negedge clk);
         n++;
         if (sample !== prev) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // stimulus
   initial begin
      logic [15:0] a_seen;
      logic [15:0] a_exp;
      logic [7:0]  b;
      bit          got;
      bit          ok;
      int          n;
      int          bad;
      int          lvl;

      repeat (3) @(negedge clk);
      check("rst_req", dma_req, 0);
      check("rst_addr", dma_addr, 0);
      check("rst_irq", irq, 0);
      check("rst_active", active, 0);
      check("rst_sample", sample, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: direct load, then silence
      pulse_direct(8'h40);
      check("t1_direct", sample, 64);
      bad = 0;
      n = 0;
      repeat (10000) begin
         @(negedge clk);
         if (dma_req !== 1'b0) n++;
         if (sample !== 7'd64) bad++;
      end
      check("t1_no_req", n, 0);
      check("t1_level_hold", bad, 0);

      // 2: single byte fetch and playback timing
      restart(8'h01, 8'h00);
      check("t2_active", active, 1);
      serve(8'hFF, 2, 20, a_seen, got);
      check("t2_got", got, 1);
      check("t2_addr", a_seen, 16'hC040);
      check("t2_active_drop", active, 0);
      check("t2_req_drop", dma_req, 0);
      wait_change(1000, n, ok);
      check("t2_first_ok", ok, 1);
      check("t2_first_lvl", sample, 66);
      for (int k = 2; k <= 8; k++) begin
         wait_change(200, n, ok);
         check("t2_step_ok", ok, 1);
         check("t2_step_period", n, 54);
         check("t2_step_lvl", sample, 32'(64 + 2 * k));
      end
      wait_change(162, n, ok);
      check("t2_hold", ok, 0);
      check("t2_final", sample, 32'(exp_level(64, 8'hFF)));

      // 3: saturation at both ends
      pulse_direct(8'h7E);
      check("t3_hi_load", sample, 126);
      restart(8'h00, 8'h00);
      serve(8'hFF, 0, 50, a_seen, got);
      check("t3_hi_got", got, 1);
      bad = 0;
      repeat (1100) begin
         @(negedge clk);
         if (sample !== 7'd126) bad++;
      end
      check("t3_hi_hold", bad, 0);
      pulse_direct(8'h01);
      restart(8'h00, 8'h00);
      serve(8'h00, 0, 50, a_seen, got);
      check("t3_lo_got", got, 1);
      bad = 0;
      repeat (1100) begin
         @(negedge clk);
         if (sample !== 7'd1) bad++;
      end
      check("t3_lo_hold", bad, 0);

      // randomized single-byte playback
      for (int it = 0; it < 4; it++) begin
         lvl = $urandom_range(0, 127);
         b = 8'($urandom_range(0, 255));
         pulse_direct(8'(lvl));
         check("rnd_direct", sample, 32'(lvl));
         restart(8'($urandom_range(0, 255)), 8'h00);
         a_exp = start_of(reg_addr);
         serve(b, $urandom_range(0, 6), 50, a_seen, got);
         check("rnd_got", got, 1);
         check("rnd_addr", a_seen, a_exp);
         repeat (1100) @(negedge clk);
         check("rnd_level", sample, 32'(exp_level(lvl, b)));
      end

      // 4: 17-byte one-shot with IRQ, then looping
      reg_ctrl = 8'h8F;
      restart(8'h10, 8'h01);
      a_exp = start_of(8'h10);
      for (int i = 0; i < 17; i++) begin
         exp_q.push_back(a_exp);
         a_exp = next_addr(a_exp);
      end
      for (int i = 0; i < 17; i++) begin
         serve(8'($urandom_range(0, 255)), $urandom_range(0, 3), 1500, a_seen, got);
         check("t4_got", got, 1);
         check("t4_addr", a_seen, exp_q.pop_front());
         if (i < 16) check("t4_irq_low", irq, 0);
      end
      check("t4_irq_set", irq, 1);
      check("t4_inactive", active, 0);
      n = 0;
      repeat (50) begin
         @(negedge clk);
         if (dma_req !== 1'b0) n++;
      end
      check("t4_no_more_req", n, 0);
      check("t4_irq_held", irq, 1);
      pulse_en(1'b0);
      check("t4_irq_clear", irq, 0);

      reg_ctrl = 8'hCF;
      restart(8'h10, 8'h01);
      a_exp = start_of(8'h10);
      for (int i = 0; i < 18; i++) begin
         exp_q.push_back(a_exp);
         a_exp = (i == 16) ? start_of(8'h10) : next_addr(a_exp);
      end
      bad = 0;
      for (int i = 0; i < 18; i++) begin
         serve(8'($urandom_range(0, 255)), $urandom_range(0, 3), 1500, a_seen, got);
         check("t4l_got", got, 1);
         check("t4l_addr", a_seen, exp_q.pop_front());
         if (irq !== 1'b0) bad++;
      end
      check("t4l_irq_never", bad, 0);
      check("t4l_active", active, 1);
      pulse_en(1'b0);
      serve(8'h00, 0, 5, a_seen, got);
      reg_ctrl = 8'h0F;

      // 5: address wrap and mid-fetch disable
      restart(8'hFF, 8'hFF);
      a_exp = start_of(8'hFF);
      for (int i = 0; i < 65; i++) begin
         exp_q.push_back(a_exp);
         a_exp = next_addr(a_exp);
      end
      for (int i = 0; i < 65; i++) begin
         serve(8'($urandom_range(0, 255)), 0, 1500, a_seen, got);
         check("t5_got", got, 1);
         check("t5_addr", a_seen, exp_q.pop_front());
      end
      wait_req(1500, got);
      check("t5_pend_got", got, 1);
      check("t5_pend_addr", dma_addr, a_exp);
      pulse_en(1'b0);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (dma_req !== 1'b1 || dma_addr !== a_exp) bad++;
      end
      check("t5_req_held", bad, 0);
      check("t5_inactive", active, 0);
      dma_data = 8'hA5;
      dma_ack = 1'b1;
      @(negedge clk);
      dma_ack = 1'b0;
      check("t5_req_drop", dma_req, 0);
      check("t5_still_inactive", active, 0);
      n = 0;
      repeat (1000) begin
         @(negedge clk);
         if (dma_req !== 1'b0) n++;
      end
      check("t5_no_more_req", n, 0);
      repeat (2500) @(negedge clk);

      // 6: ack hold-off, direct load racing an output clock, async reset
      pulse_direct(8'h0A);
      restart(8'h20, 8'h00);
      wait_req(50, got);
      check("t6_got", got, 1);
      check("t6_addr", dma_addr, 16'hC800);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (dma_req !== 1'b1 || dma_addr !== 16'hC800) bad++;
      end
      check("t6_stable", bad, 0);
      dma_data = 8'hFF;
      dma_ack = 1'b1;
      @(negedge clk);
      dma_ack = 1'b0;
      wait_change(1000, n, ok);
      check("t6_change_ok", ok, 1);
      check("t6_first_lvl", sample, 12);
      repeat (53) @(negedge clk);
      pulse_direct(8'h30);
      check("t6_direct_wins", sample, 48);
      repeat (54) @(negedge clk);
      check("t6_next_delta", sample, 50);

      restart(8'h00, 8'h00);
      wait_req(50, got);
      check("t6r_got", got, 1);
      rst_n = 1'b0;
      #1;
      check("t6r_req_async", dma_req, 0);
      check("t6r_addr_async", dma_addr, 0);
      check("t6r_active_async", active, 0);
      check("t6r_sample_async", sample, 0);
      dma_data = 8'h55;
      dma_ack = 1'b1;
      @(negedge clk);
      dma_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (200) begin
         @(negedge clk);
         if (dma_req !== 1'b0) n++;
      end
      check("t6r_no_req", n, 0);
      check("t6r_active", active, 0);
      check("t6r_sample", sample, 0);

      // report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apu_dmc.md
Name: apu_dmc

Overview:
- Delta-modulation (DMC) sample channel for the APU. It replaces the constant-zero DMC sample and the tied-off dmc_irq/dmc_active signals.
- Fetches 1-bit delta sample bytes from CPU address space through a request/acknowledge handshake to the bus/DMA arbiter, then buffers them in a parametrised FIFO.
- Produces a delta-coded level for the mixer, plus the status bit and IRQ for $4015.

Parameters:
- OUT_WIDTH, 7: output level width, minimum 7. The delta step is 2 << (OUT_WIDTH-7).
- BUF_DEPTH, 1: sample-byte FIFO depth, 1..4. A depth of 1 is NES-exact.
- LEN_WIDTH, 12: bytes-remaining counter width, minimum 12.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_tick  in  1  one-cycle pulse per CPU cycle
- reg_ctrl  in  8  $4010 value: [7] irq_en, [6] loop, [3:0] rate index
- reg_direct  in  8  $4011 value: [6:0] direct load
- reg_addr  in  8  $4012 value
- reg_length  in  8  $4013 value
- ctrl_update, direct_update, addr_update, length_update  in  1  one-cycle write strobes
- en  in  1  $4015 bit 4
- en_update  in  1  one-cycle strobe on a $4015 write
- dma_req  out  1  fetch request
- dma_addr  out  16  fetch address
- dma_ack  in  1  one-cycle acknowledge; dma_data is valid in the same cycle
- dma_data  in  8  fetched byte
- active  out  1  bytes_remaining != 0
- irq  out  1  DMC interrupt flag
- sample  out  OUT_WIDTH  output level

Behaviour:

Reset values:
- dma_req=0, dma_addr=0, irq=0, active=0, sample=0.
- FIFO empty, silence=1, bits_left=8, timer=0, cur_addr=16'hC000, bytes_remaining=0.

Rate timer:
- Period table, indexed by ctrl[3:0], in CPU cycles: 428,380,340,320,286,254,226,214,190,160,142,128,106,84,72,54.
- On cpu_tick: if timer==0, reload timer=period-1 and generate an output clock; otherwise decrement.

Output unit (on each output clock):
- If !silence: when shift[0]=1 and level <= MAX-step, level += step. When shift[0]=0 and level >= step, level -= step. MAX = 2^OUT_WIDTH-1. Saturation means no change and no wrap.
- Then shift >>= 1 and bits_left -= 1.
- When bits_left reaches 0, in the same clock: bits_left=8. If the FIFO is non-empty, pop into shift and set silence=0. Otherwise set silence=1.

Direct load:
- direct_update sets level = {reg_direct[6:0], (OUT_WIDTH-7)'b0}.
- If it coincides with an output clock, the direct load wins and the delta is discarded.

Memory reader:
- Restart means cur_addr = 16'hC000 + reg_addr*64 and bytes_remaining = reg_length*16 + 1.
- en_update with en=1 and bytes_remaining==0: restart. With en=1 and bytes_remaining!=0: no change.
- en_update with en=0: bytes_remaining=0.
- Every en_update clears irq.
- ctrl_update with reg_ctrl[7]=0 clears irq.

Fetch handshake:
- Request when the FIFO is not full, bytes_remaining!=0 and no request is outstanding.
- The request registers dma_req=1 and dma_addr=cur_addr.
- dma_req and dma_addr hold stable until dma_ack. dma_req drops in the cycle after ack. At most one request is outstanding.
- On ack:
  - Push dma_data into the FIFO.
  - cur_addr += 1, wrapping 16'hFFFF to 16'h8000.
  - bytes_remaining -= 1.
- If bytes_remaining becomes 0 on that ack: with loop=1, restart in the same cycle. With loop=0 and irq_en=1, set irq=1.

Mid-fetch disable and FIFO bounds:
- An outstanding request always completes, even if en goes 0. The acked byte is still pushed, but bytes_remaining stays 0.
- A push to a full FIFO cannot occur because no request is issued when full.
- A simultaneous pop and push in the same cycle are both honoured.

Output mapping:
- sample = level, registered.
- active = (bytes_remaining != 0), registered.

Reset mid-operation:
- Asynchronous reset returns every state to the reset values immediately.
- A pending dma_req drops and no ack is consumed.

Test Plan:
1. Reset, then reg_direct=8'h40 with direct_update -> sample=64 (OUT_WIDTH=7); dma_req stays 0 and level is unchanged over 10000 ticks (silence).
2. reg_addr=8'h01, reg_length=8'h00, en=1 with en_update -> dma_req=1 with dma_addr=16'hC040; ack with 8'hFF -> active drops to 0. With rate index 15, level rises by 2 every 54 ticks from the first unsilenced bit: 8 increments, then holds.
3. Start at level 126 with byte 8'hFF -> level saturates at 126. Start at level 1 with byte 8'h00 -> level stays 1 with no wrap.
4. reg_length=8'h01 (17 bytes), loop=0, irq_en=1 -> irq asserts on the 17th ack and active=0. An en_update write clears irq. Repeat with loop=1 -> address returns to the start, irq never asserts, active stays 1.
5. reg_addr=8'hFF, reg_length=8'hFF -> after dma_addr 16'hFFFF, the next dma_addr is 16'h8000. Set en=0 while dma_req=1 -> req holds until ack, active=0, and no further requests.
6. BUF_DEPTH=4, ack held off 20 cycles -> dma_req/dma_addr stay stable. A direct_update coincident with an output clock -> direct value wins. Assert rst_n low mid-request -> dma_req=0 asynchronously.
